// File: rtl/divisor_param.sv
// Multi-cycle restoring divider that produces one quotient bit per clock and uses a start/busy/done handshake.
// Define DIVISOR_SIGNED_EN to add the signed_op port and two's-complement division that truncates toward zero.
module divisor_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIVISOR_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] residuo,
    output logic             div_cero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_nx;
    logic [WIDTH-1:0] q_nx;
    logic             sa;
    logic             sb;

    // Two's-complement negate when requested. This function is used for both magnitude extraction and the final sign fix-up.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

`ifdef DIVISOR_SIGNED_EN
    always_comb begin
        sa = signed_op & a[WIDTH-1];
        sb = signed_op & b[WIDTH-1];
    end
`else
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
    end
`endif

    // One restoring step. The partial remainder is always below D, so bit WIDTH of R is zero before the shift.
    always_comb begin
        r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
        t    = r_sh - {1'b0, d};
        if (!t[WIDTH]) begin
            r_nx = t;
            q_nx = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_nx = r_sh;
            q_nx = {q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_cero <= 1'b0;
            cociente <= '0;
            residuo  <= '0;
            q        <= '0;
            d        <= '0;
            r        <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        q    <= a;
                        if (b == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cociente <= '1;
                            residuo  <= a;
                            div_cero <= 1'b1;
                        end else begin
                            q        <= apply_sign(a, sa);
                            d        <= apply_sign(b, sb);
                            r        <= '0;
                            cnt      <= '0;
                            neg_q    <= sa ^ sb;
                            neg_r    <= sa;
                            div_cero <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    q   <= q_nx;
                    r   <= r_nx;
                    cnt <= cnt + CNT_W'(1);
                    // Results are registered on entry to DONE, so done and the outputs appear together.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cociente <= apply_sign(q_nx, neg_q);
                        residuo  <= apply_sign(r_nx[WIDTH-1:0], neg_r);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/divisor_param.md
Name: divisor_param

Overview:
- Parametrised multi-cycle unsigned integer divider (restoring algorithm), one quotient bit per clock.
- Successor to the fixed 8-bit divider in the ALU. Adds generic width, a start/busy/done handshake, divide-by-zero detection and optional signed mode.
- Sits in the ALU datapath and is driven by the ALU control FSM.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low (rst=0 at a rising clk edge resets the block).
- start  input  1  request pulse; accepted only in IDLE.
- a  input  WIDTH  dividend; sampled on accepted start.
- b  input  WIDTH  divisor; sampled on accepted start.
- busy  output  1  high while an operation is in progress (CALC or DONE).
- done  output  1  one-cycle pulse when results are valid.
- cociente  output  WIDTH  quotient, registered.
- residuo  output  WIDTH  remainder, registered.
- div_cero  output  1  set with done when b==0; held until next accepted start.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; busy, done, div_cero = 0; cociente, residuo = 0; internal registers and counter = 0. Reset overrides everything, including mid-operation; the aborted operation produces no done.
- IDLE: busy=0.
  - start=1 with b!=0: latch a into quotient shift register Q, b into D, clear partial remainder R (WIDTH+1 bits), counter=0, clear div_cero, go to CALC.
  - start=1 with b==0: latch a, go to DONE with the zero-divide flag pending.
- CALC: busy=1. Each cycle:
  - {R,Q} shifts left by 1.
  - T = R_shifted − {0,D}. If T is non-negative, R=T and Q[0]=1; otherwise R is kept and Q[0]=0.
  - counter increments. When counter reaches WIDTH−1 on this cycle, go to DONE (exactly WIDTH CALC cycles).
- DONE: busy=1, done=1 for exactly one cycle.
  - Normal case: cociente=Q, residuo=R[WIDTH-1:0], div_cero=0.
  - Divide-by-zero case: cociente = all ones, residuo = a latched, div_cero=1.
  - Next state is IDLE.
- Latency: start accepted at edge N gives done high during cycle N+WIDTH+1. Divide by zero: done during cycle N+1.
- Outputs cociente, residuo and div_cero hold their last values until the next DONE or reset.
- start while busy=1 is ignored; operands are not resampled.
- start asserted in the same cycle as done: not accepted (state is DONE). It is accepted on the following IDLE cycle if start is still high.
- Invariant on normal completion: a == cociente*b + residuo, and residuo < b.
- a < b gives cociente=0, residuo=a. a==0 gives 0 and 0.

Optional Feature:
- Macro: DIVISOR_SIGNED_EN.
- When defined:
  - Adds input port signed_op (1 bit), sampled with the operands.
  - With signed_op=1, a and b are two's complement. The core divides magnitudes; in DONE the quotient is negated if the operand signs differ, and the remainder takes the sign of a (truncation toward zero).
  - MIN/−1 yields cociente=MIN and residuo=0, with no extra flag.
  - b==0 in signed mode behaves exactly as in unsigned mode.
  - Latency is unchanged.
- When undefined: no signed_op port; all operations are unsigned; sign logic is absent.

Test Plan:
- WIDTH=8: a=8, b=4, start pulse → done 9 cycles after the accept edge; cociente=2, residuo=0, div_cero=0.
- WIDTH=8 back-to-back: 9/2 → 4 r1; then 156/43 → 3 r27; then 1/1 → 1 r0. busy stays low exactly one cycle between operations.
- WIDTH=8: a=200, b=0 → done on the next cycle; cociente=255, residuo=200, div_cero=1. A following 5/7 → 0 r5, div_cero=0.
- WIDTH=8: start 100/7, pulse start=1 with a=3, b=1 during CALC, then assert rst=0 at cycle 4 → no done pulse; all outputs 0; the next 100/7 → 14 r2.
- WIDTH=16: a=65535, b=255 → 257 r0, done 17 cycles after accept; a=40000, b=333 → 120 r40.
- DIVISOR_SIGNED_EN, WIDTH=8, signed_op=1:
  - −9/2 → cociente=−4 (0xFC), residuo=−1 (0xFF).
  - 9/−2 → −4 r1.
  - −128/−1 → −128 r0.
  - signed_op=0 with 0xF7/2 → 123 r1.
